bcd_gray_sched: RTL and testbench

BCD_GRAY_SCHED -- requirements
Module: bcd_gray_sched

---
 rtl/bcd_gray_pkg.sv | 14 +
 rtl/bcd_digit_gray.sv | 13 +
 rtl/bcd_gray_sched.sv | 118 +++++++++++
 tb/tb_bcd_gray_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_gray_pkg.sv
// Shared definitions for the BCD-to-Gray scheduler: FSM state encoding,
// digit width and the largest legal BCD digit value.
package bcd_gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit_gray.sv
// Combinational single-digit converter, binary nibble to reflected Gray code.
// Digits above 9 are converted with the same equations.
module bcd_digit_gray
    import bcd_gray_pkg::*;
(
    input  logic [DIG_W-1:0] bcd,
    output logic [DIG_W-1:0] gray
);

    // Each Gray bit is the XOR of neighbouring binary bits; the MSB passes through.
    assign gray = {bcd[3], bcd[3] ^ bcd[2], bcd[2] ^ bcd[1], bcd[1] ^ bcd[0]};

endmodule

// File: rtl/bcd_gray_sched.sv
// Sequential BCD-to-Gray word converter. A captured word is converted one
// digit per cycle (LSD first) through a single shared digit converter, then
// held in DONE until the consumer takes it.
// Optional feature: define BCD_CHECK_EN to flag digits greater than 9 on
// out_err; without it out_err is tied low.
module bcd_gray_sched
    import bcd_gray_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*NDIG-1:0]     in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*NDIG-1:0]     out_gray,
    output logic                  out_err,
    output logic                  busy
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                   state;
    state_t                   state_next;
    logic [IDX_W-1:0]         idx;
    logic [DIG_W*NDIG-1:0]    word_q;
    logic [DIG_W*NDIG-1:0]    gray_q;
    logic [DIG_W-1:0]         digit_sel;
    logic [DIG_W-1:0]         digit_gray;
    logic                     accept;
    logic                     last_digit;

    assign accept     = (state == ST_IDLE) && in_valid;
    assign last_digit = (idx == IDX_W'(NDIG - 1));

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_gray  = gray_q;

    // State register; reset drops any word in flight back to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: capture, walk the digits, wait for the output handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)   state_next = ST_CONV;
            ST_CONV: if (last_digit) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Select the digit addressed by idx for the shared converter.
    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IDX_W'(i)) begin
                digit_sel = word_q[i*DIG_W +: DIG_W];
            end
        end
    end

    bcd_digit_gray u_digit (
        .bcd  (digit_sel),
        .gray (digit_gray)
    );

    // Word capture, digit index and result slots; unwritten slots keep old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            idx    <= '0;
            gray_q <= '0;
        end else if (accept) begin
            word_q <= in_bcd;
            idx    <= '0;
        end else if (state == ST_CONV) begin
            for (int i = 0; i < NDIG; i++) begin
                if (idx == IDX_W'(i)) begin
                    gray_q[i*DIG_W +: DIG_W] <= digit_gray;
                end
            end
            if (!last_digit) begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic err_q;

    // Sticky out-of-range flag, cleared when a new word is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if ((state == ST_CONV) && (digit_sel > BCD_MAX)) begin
            err_q <= 1'b1;
        end
    end

    assign out_err = (state == ST_DONE) && err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_gray_sched.sv
// Self-checking bench for bcd_gray_sched: directed words with literal
// expectations plus a randomized phase checked every cycle against a
// transaction-level model of the converter.
module tb_bcd_gray_sched;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;
`ifdef BCD_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_bcd;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gray;
    logic         out_err;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    bcd_gray_sched #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_err   (out_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: Gray of each nibble is d ^ (d >> 1).
    function automatic logic [W-1:0] gray_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        logic [3:0]   d;
        r = '0;
        for (int i = 0; i < NDIG; i++) begin
            d = w[i*4 +: 4];
            r[i*4 +: 4] = d ^ (d >> 1);
        end
        return r;
    endfunction

    function automatic logic any_bad_digit(input logic [W-1:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (w[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Transaction model: busy from accept to output handshake, m_k edges elapsed.
    bit           m_busy = 1'b0;
    int           m_k    = 0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_old  = '0;
    logic [W-1:0] m_gray = '0;

    function automatic logic [W-1:0] model_gray();
        logic [W-1:0] r;
        logic [W-1:0] full;
        if (!m_busy) return m_gray;
        full = gray_word(m_word);
        r = m_old;
        for (int i = 0; i < NDIG; i++) begin
            if (i < m_k) r[i*4 +: 4] = full[i*4 +: 4];
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_gray = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_k    = 0;
                m_word = in_bcd;
                m_old  = m_gray;
            end
        end else if (m_k < NDIG) begin
            m_k = m_k + 1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_gray = gray_word(m_word);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            checkOutput("in_ready",  32'(in_ready),  32'(!m_busy));
            checkOutput("busy",      32'(busy),      32'(m_busy));
            checkOutput("out_valid", 32'(out_valid), 32'(m_busy && (m_k == NDIG)));
            checkOutput("out_gray",  32'(out_gray),  32'(model_gray()));
            if (m_busy && (m_k == NDIG)) begin
                checkOutput("out_err", 32'(out_err), 32'(CHECK_EN && any_bad_digit(m_word)));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] word, input bit keep_valid);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk); #2;
            guard++;
        end
        checkOutput("accept_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_bcd   = word;
        @(posedge clk);
        @(negedge clk); #2;
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic waitValid(output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            edges++;
            @(negedge clk); #1;
        end while (!out_valid && edges < 100);
        #1;
    endtask

    task automatic handshake(input int hold, input logic [W-1:0] exp_gray);
        repeat (hold) begin
            @(negedge clk); #1;
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_gray",  32'(out_gray),  32'(exp_gray));
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #2;
        out_ready = 1'b0;
        checkOutput("post_hs_ready", 32'(in_ready),  32'd1);
        checkOutput("post_hs_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;
        rst = 1'b1; in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
        #12;
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("rst_ready", 32'(in_ready),  32'd1);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_gray",  32'(out_gray),  32'd0);
        checkOutput("rst_err",   32'(out_err),   32'd0);
        #1;

        applyStimulus(16'h0000, 1'b0);
        waitValid(edges);
        checkOutput("zero_latency", 32'(edges), 32'(NDIG));
        checkOutput("zero_gray", 32'(out_gray), 32'h0000);
        checkOutput("zero_err",  32'(out_err),  32'd0);
        handshake(0, 16'h0000);

        applyStimulus(16'h1234, 1'b1);
        in_bcd = 16'h9876;
        waitValid(edges);
        checkOutput("w1234_latency", 32'(edges), 32'(NDIG));
        checkOutput("w1234_gray", 32'(out_gray), 32'h1326);
        handshake(0, 16'h1326);
        @(posedge clk);
        @(negedge clk); #2;
        in_valid = 1'b0;
        waitValid(edges);
        checkOutput("w9876_latency", 32'(edges), 32'(NDIG));
        checkOutput("w9876_gray", 32'(out_gray), 32'hDC45);
        handshake(3, 16'hDC45);

        applyStimulus(16'h12A4, 1'b0);
        waitValid(edges);
        checkOutput("w12A4_gray", 32'(out_gray), 32'h13F6);
        checkOutput("w12A4_err",  32'(out_err),  32'(CHECK_EN));
        handshake(1, 16'h13F6);

        applyStimulus(16'h4321, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_gray",  32'(out_gray),  32'd0);
        checkOutput("midrst_busy",  32'(busy),      32'd0);
        checkOutput("midrst_ready", 32'(in_ready),  32'd1);
        @(negedge clk); #2;
        rst = 1'b0;
        applyStimulus(16'h0005, 1'b0);
        waitValid(edges);
        checkOutput("w0005_latency", 32'(edges), 32'(NDIG));
        checkOutput("w0005_gray", 32'(out_gray), 32'h0007);
        checkOutput("w0005_err",  32'(out_err),  32'd0);
        handshake(0, 16'h0007);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk); #2;
            in_valid  = 1'($urandom_range(0, 1));
            in_bcd    = W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk); #2;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
